// File: rtl/encrypt_stream_if.sv
// Handshake bundle for encrypt_stream: message control, operand beat channel and row-result channel.
// master drives stimulus and consumes results; slave is the accumulator side.
interface encrypt_stream_if #(
   parameter int PLAINTEXT_WIDTH  = 6,
   parameter int CIPHERTEXT_WIDTH = 32,
   parameter int DIM_WIDTH        = 7,
   parameter int LANES            = 4
);
   logic                              start;
   logic [PLAINTEXT_WIDTH-1:0]        plaintext;
   logic                              in_valid;
   logic                              in_ready;
   logic [DIM_WIDTH:0]                in_row;
   logic                              in_last;
   logic [LANES-1:0]                  lane_mask;
   logic [LANES*CIPHERTEXT_WIDTH-1:0] op1;
   logic [LANES*CIPHERTEXT_WIDTH-1:0] op2;
   logic                              out_valid;
   logic                              out_ready;
   logic [CIPHERTEXT_WIDTH-1:0]       out_data;
   logic [DIM_WIDTH:0]                out_row;
   logic                              out_last;
   logic                              busy;
   logic                              err;

   modport master (
      output start, plaintext, in_valid, in_row, in_last, lane_mask, op1, op2, out_ready,
      input  in_ready, out_valid, out_data, out_row, out_last, busy, err
   );

   modport slave (
      input  start, plaintext, in_valid, in_row, in_last, lane_mask, op1, op2, out_ready,
      output in_ready, out_valid, out_data, out_row, out_last, busy, err
   );
endinterface

// File: rtl/encrypt_stream.sv
// Streaming multi-lane LWE row accumulator: reduces lane beats mod q per row, adds delta*m into the b-row.
// Optional protocol/operand checking is enabled by defining ENCRYPT_STREAM_CHECK_EN.
module encrypt_stream #(
   parameter int PLAINTEXT_WIDTH    = 6,
   parameter int CIPHERTEXT_MODULUS = 1024,
   parameter int CIPHERTEXT_WIDTH   = 32,
   parameter int DIMENSION          = 128,
   parameter int DIM_WIDTH          = 7,
   parameter int LANES              = 4
) (
   input logic             clk,
   input logic             rst_n,
   encrypt_stream_if.slave bus
);
   localparam int CW = CIPHERTEXT_WIDTH;
   localparam int RW = DIM_WIDTH + 1;
   localparam logic [CW:0]   Q_EXT = (CW+1)'(CIPHERTEXT_MODULUS);
   localparam logic [CW-1:0] DELTA = CW'(CIPHERTEXT_MODULUS >> PLAINTEXT_WIDTH);
   localparam logic [RW-1:0] B_ROW = RW'(DIMENSION);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t        state_r;
   logic [CW-1:0] acc_r;
   logic [CW-1:0] delta_m_r;
   logic [RW-1:0] cur_row_r;
   logic          first_r;
   logic          out_valid_r;
   logic [CW-1:0] out_data_r;
   logic [RW-1:0] out_row_r;
   logic          out_last_r;
   logic          err_r;

   logic          in_ready_s;
   logic          accept_s;
   logic          same_row_s;
   logic          drop_s;
   logic [CW-1:0] beat_sum_s;
   logic [CW-1:0] merged_s;
   logic [CW-1:0] close_val_s;
   logic [CW-1:0] last_val_s;

   // Both inputs are below q, so one conditional subtract keeps the result below q.
   function automatic logic [CW-1:0] madd(input logic [CW-1:0] a, input logic [CW-1:0] b);
      logic [CW:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum >= Q_EXT) ? CW'(sum - Q_EXT) : sum[CW-1:0];
   endfunction

   function automatic logic [CW-1:0] lane_sum(input logic [LANES-1:0]    mask,
                                              input logic [LANES*CW-1:0] a,
                                              input logic [LANES*CW-1:0] b);
      logic [CW-1:0] s;
      s = '0;
      for (int i = 0; i < LANES; i++) begin
         s = mask[i] ? madd(madd(s, a[i*CW +: CW]), b[i*CW +: CW]) : s;
      end
      return s;
   endfunction

   function automatic logic [CW-1:0] row_bias(input logic [RW-1:0] row, input logic [CW-1:0] dm);
      return (row == B_ROW) ? dm : '0;
   endfunction

`ifdef ENCRYPT_STREAM_CHECK_EN
   function automatic logic operand_bad(input logic [LANES-1:0]    mask,
                                        input logic [LANES*CW-1:0] a,
                                        input logic [LANES*CW-1:0] b);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         bad = bad | (mask[i] & (({1'b0, a[i*CW +: CW]} >= Q_EXT) |
                                 ({1'b0, b[i*CW +: CW]} >= Q_EXT)));
      end
      return bad;
   endfunction

   // The first beat of a message may open on any legal row; ordering is enforced afterwards.
   function automatic logic row_bad(input logic [RW-1:0] row, input logic [RW-1:0] cur, input logic first);
      logic order_bad;
      order_bad = (row < cur) || ({1'b0, row} > ({1'b0, cur} + (RW+1)'(1)));
      return (row > B_ROW) || (!first && order_bad);
   endfunction
`endif

   // Beat reduction, handshake qualification and the candidate value for each way a row closes
   always_comb begin
      beat_sum_s  = lane_sum(bus.lane_mask, bus.op1, bus.op2);
      merged_s    = madd(acc_r, beat_sum_s);
      close_val_s = madd(acc_r, row_bias(cur_row_r, delta_m_r));
      last_val_s  = madd(merged_s, row_bias(bus.in_row, delta_m_r));
      in_ready_s  = (state_r == ST_ACCUM) && (!out_valid_r || bus.out_ready);
      accept_s    = bus.in_valid && in_ready_s;
      same_row_s  = first_r || (bus.in_row == cur_row_r);
`ifdef ENCRYPT_STREAM_CHECK_EN
      drop_s      = operand_bad(bus.lane_mask, bus.op1, bus.op2) ||
                    row_bad(bus.in_row, cur_row_r, first_r);
`else
      drop_s      = 1'b0;
`endif
   end

   // Message sequencing, row accumulation and the single-entry result register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         acc_r       <= '0;
         delta_m_r   <= '0;
         cur_row_r   <= '0;
         first_r     <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_row_r   <= '0;
         out_last_r  <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  state_r   <= ST_ACCUM;
                  delta_m_r <= DELTA * CW'(bus.plaintext);
                  acc_r     <= '0;
                  cur_row_r <= '0;
                  first_r   <= 1'b1;
                  err_r     <= 1'b0;
               end
            end
            ST_ACCUM: begin
               if (accept_s) begin
                  if (drop_s) begin
                     err_r <= 1'b1;
                     if (bus.in_last) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= close_val_s;
                        out_row_r   <= cur_row_r;
                        out_last_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                     end
                  end else if (same_row_s) begin
                     acc_r     <= merged_s;
                     cur_row_r <= bus.in_row;
                     first_r   <= 1'b0;
                     if (bus.in_last) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= last_val_s;
                        out_row_r   <= bus.in_row;
                        out_last_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                     end
                  end else begin
                     // Row boundary: publish the finished row, open the new one with this beat.
                     out_valid_r <= 1'b1;
                     out_data_r  <= close_val_s;
                     out_row_r   <= cur_row_r;
                     out_last_r  <= 1'b0;
                     acc_r       <= beat_sum_s;
                     cur_row_r   <= bus.in_row;
                     if (bus.in_last) begin
                        state_r <= ST_FLUSH;
                     end
                  end
               end
            end
            ST_FLUSH: begin
               if (!out_valid_r || bus.out_ready) begin
                  out_valid_r <= 1'b1;
                  out_data_r  <= close_val_s;
                  out_row_r   <= cur_row_r;
                  out_last_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_row   = out_row_r;
   assign bus.out_last  = out_last_r;
   assign bus.busy      = (state_r != ST_IDLE);
   assign bus.err       = err_r;
endmodule
